// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned IDX_W  = 3;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, BLANK, LIT} scan_state_e;

  typedef struct packed {
    logic       blank;
    logic [3:0] hex;
  } code_t;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display-buffer write port between the system FSM and the scanner.
interface seven_segment_scanner_if;
  import seg_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_index;
  code_t            wr_code;

  modport master (output wr_valid, output wr_index, output wr_code, input wr_ready);
  modport slave  (input wr_valid, input wr_index, input wr_code, output wr_ready);
endinterface

// File: rtl/seven_segment_scanner_decoder.sv
// Combinational 5-bit display code to active-high 7-segment pattern.
module hex7seg_decoder
  import seg_pkg::*;
(
  input  code_t             code,
  output logic [SEG_W-1:0]  seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!code.blank) begin
      case (code.hex)
        4'h0: seg_c = SEG_0;
        4'h1: seg_c = SEG_1;
        4'h2: seg_c = SEG_2;
        4'h3: seg_c = SEG_3;
        4'h4: seg_c = SEG_4;
        4'h5: seg_c = SEG_5;
        4'h6: seg_c = SEG_6;
        4'h7: seg_c = SEG_7;
        4'h8: seg_c = SEG_8;
        4'h9: seg_c = SEG_9;
        4'hA: seg_c = SEG_A;
        4'hB: seg_c = SEG_B;
        4'hC: seg_c = SEG_C;
        4'hD: seg_c = SEG_D;
        4'hE: seg_c = SEG_E;
        default: seg_c = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller: blank gap, then one lit digit, per buffer entry.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIGIT_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  seven_segment_scanner_if.slave wr,
  output logic [NUM_DIGITS-1:0]  digit_en,
  output logic [SEG_W-1:0]       seg_out,
  output logic                   frame_tick
);

  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned PTR_W   = $clog2(NUM_DIGITS);
  localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  scan_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  code_t            buffer [NUM_DIGITS];
  logic [SEG_W-1:0] seg_c;

  hex7seg_decoder u_dec (
    .code  (buffer[ptr]),
    .seg_c (seg_c)
  );

  // Ready is simply "out of reset"; out-of-range indices are swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr.wr_ready <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) buffer[i] <= CODE_W'(5'h10);
    end else begin
      wr.wr_ready <= 1'b1;
      if (wr.wr_valid && wr.wr_ready && (32'(wr.wr_index) < NUM_DIGITS))
        buffer[wr.wr_index[PTR_W-1:0]] <= wr.wr_code;
    end
  end

  // Scan FSM; segments are captured on LIT entry so mid-period writes never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      digit_en   <= '0;
      seg_out    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        cnt      <= '0;
        ptr      <= '0;
        digit_en <= '0;
        seg_out  <= SEG_OFF;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
          end
          BLANK: begin
            if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
              state    <= LIT;
              cnt      <= '0;
              digit_en <= NUM_DIGITS'(1) << ptr;
              seg_out  <= seg_c ^ SEG_OFF;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LIT: begin
            if (cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
              state      <= BLANK;
              cnt        <= '0;
              digit_en   <= '0;
              seg_out    <= SEG_OFF;
              frame_tick <= (ptr == PTR_W'(NUM_DIGITS - 1));
              ptr        <= (ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : ptr + PTR_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed + random bench for seven_segment_scanner against a timeline model.
module tb_seven_segment_scanner;

  localparam int N = 4;
  localparam int D = 4;
  localparam int B = 2;
  localparam int P = B + D;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic [N-1:0] digit_en;
  logic [6:0]   seg_out;
  logic         frame_tick;

  seven_segment_scanner_if wr_if ();

  seven_segment_scanner #(
    .NUM_DIGITS(N), .DIGIT_CYCLES(D), .BLANK_CYCLES(B), .ACTIVE_LOW_SEG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr_if.slave),
    .digit_en(digit_en), .seg_out(seg_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: buffer contents, code latched at each digit's LIT entry, and elapsed cycles.
  logic [4:0] mb   [N];
  logic [4:0] snap [N];
  bit  run;
  int  k;
  int  m_d;
  bit  m_lit;
  logic [6:0] hexseg [16];

  function automatic logic [6:0] dec_low(input logic [4:0] c);
    logic [6:0] hi;
    hi = c[4] ? 7'h00 : hexseg[c[3:0]];
    return ~hi;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mb[i] = 5'h10; snap[i] = 5'h10; end
    run = 0; k = 0; m_d = 0; m_lit = 0;
  endtask

  // One clock: model steps with the inputs seen at the edge, then outputs are compared.
  task automatic tick();
    bit         en_s, wv;
    logic [2:0] wi;
    logic [4:0] wc;
    int         ph;
    logic [N-1:0] exp_en;
    logic [6:0]   exp_seg;
    bit           exp_ft;
    en_s = enable; wv = wr_if.wr_valid; wi = wr_if.wr_index; wc = wr_if.wr_code;
    @(posedge clk); #1;
    if (!en_s) run = 0;
    else if (!run) begin run = 1; k = 0; end
    else k++;
    ph = k % P;
    m_d = (k / P) % N;
    m_lit = run && (ph >= B);
    if (run && ph == B) snap[m_d] = mb[m_d];
    if (wv && int'(wi) < N) mb[wi] = wc;
    exp_en  = m_lit ? N'(1) << m_d : '0;
    exp_seg = m_lit ? dec_low(snap[m_d]) : 7'h7F;
    exp_ft  = run && k > 0 && (k % (P * N)) == 0;
    chk("digit_en", 32'(digit_en), 32'(exp_en));
    chk("seg_out", 32'(seg_out), 32'(exp_seg));
    chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
    chk("wr_ready", 32'(wr_if.wr_ready), 32'd1);
  endtask

  task automatic write(input logic [2:0] idx, input logic [4:0] code);
    wr_if.wr_valid = 1'b1; wr_if.wr_index = idx; wr_if.wr_code = code;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic run_until_lit(input int d, input string tag);
    for (int i = 0; i < 200 && !(m_lit && m_d == d); i++) tick();
    chk(tag, 32'(digit_en), 32'(N'(1) << d));
  endtask

  initial begin
    hexseg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    rst_n = 1'b0; enable = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_index = '0; wr_if.wr_code = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit_en", 32'(digit_en), 32'd0);
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_ready", 32'(wr_if.wr_ready), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Load {1,2,3,4} and scan two full frames
    for (int i = 0; i < N; i++) write(3'(i), 5'(i + 1));
    enable = 1'b1;
    repeat (2 * P * N + 2) tick();

    // Write to digit 2 while it is lit: old value holds, new one on next visit
    run_until_lit(2, "reach_d2");
    chk("d2_before", 32'(seg_out), 32'h30);
    write(3'd2, 5'h0A);
    chk("d2_held", 32'(seg_out), 32'h30);
    repeat (P) tick();
    run_until_lit(2, "reach_d2_again");
    chk("d2_new", 32'(seg_out), 32'h08);

    // Blank code on digit 0, out-of-range index 6 ignored
    write(3'd0, 5'h10);
    write(3'd6, 5'h10);
    run_until_lit(0, "reach_d0_blank");
    chk("d0_blank", 32'(seg_out), 32'h7F);
    repeat (P * N) tick();

    // Random writes and occasional enable drops
    for (int i = 0; i < 400; i++) begin
      wr_if.wr_valid = ($urandom_range(0, 3) == 0);
      wr_if.wr_index = 3'($urandom_range(0, 7));
      wr_if.wr_code  = 5'($urandom);
      enable = ($urandom_range(0, 39) != 0);
      tick();
    end
    wr_if.wr_valid = 1'b0;
    enable = 1'b1;
    tick();

    // Enable drop during digit 1, then restart from BLANK and digit 0
    run_until_lit(1, "reach_d1");
    enable = 1'b0;
    tick();
    chk("drop_off", 32'(digit_en), 32'd0);
    tick();
    enable = 1'b1;
    tick();
    chk("restart_blank", 32'(digit_en), 32'd0);
    repeat (B) tick();
    chk("restart_d0", 32'(digit_en), 32'd1);
    repeat (P * N) tick();

    // Async reset between edges while lit
    run_until_lit(3, "reach_d3");
    #3 rst_n = 1'b0;
    #1;
    chk("async_digit_en", 32'(digit_en), 32'd0);
    chk("async_seg", 32'(seg_out), 32'h7F);
    chk("async_ready", 32'(wr_if.wr_ready), 32'd0);
    model_reset();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    repeat (P * N + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
